fetch_decode_buffer: RTL

//   IF->ID pipeline stage. Takes 16-bit words from fetch and emits one complete instruction per valid

---
 rtl/proc_pkg.sv | 14 +
 rtl/pipe_reg_en.sv | 21 ++
 rtl/fetch_decode_buffer.sv | 118 +++++++++++
 3 files changed

// File: rtl/proc_pkg.sv
// Shared types and widths for the processor front end.
// The IF->ID buffer uses these for its FSM state and word/PC sizing.
package proc_pkg;

    localparam int WORD_W       = 16;
    localparam int PC_W         = 32;
    localparam int IMM_FLAG_BIT = 0;

    typedef enum logic {
        S_FIRST = 1'b0,
        S_IMM   = 1'b1
    } fd_state_t;

endpackage

// File: rtl/pipe_reg_en.sv
// Pipeline register with synchronous clear, load enable and hold.
// Clear wins over enable; with neither asserted the value is held.
module pipe_reg_en #(
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         en,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    always_ff @(posedge clk) begin
        if (clear) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_decode_buffer.sv
// IF->ID stage: assembles one- or two-word instructions from the fetch stream
// and presents one complete instruction per valid cycle to decode.
module fetch_decode_buffer
    import proc_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] in_word,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              in_valid,
    input  logic              stall,
    input  logic              flush,
    output logic [WORD_W-1:0] out_instr,
    output logic [WORD_W-1:0] out_imm,
    output logic [PC_W-1:0]   out_pc,
    output logic              out_has_imm,
    output logic              out_valid,
    output logic              awaiting_imm
);

    fd_state_t         state;
    fd_state_t         state_next;
    logic              first_we;
    logic              imm_we;
    logic [WORD_W-1:0] imm_d;
    logic              valid_d;
    logic              has_imm_d;
    logic              data_hold;
    logic              is_two_word;
    logic [1:0]        flags_q;

    assign data_hold    = flush | stall;
    assign is_two_word  = in_word[IMM_FLAG_BIT];
    assign awaiting_imm = (state == S_IMM);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state <= S_FIRST;
        end else if (!stall) begin
            state <= state_next;
        end
    end

    // Next state plus load decisions for the output registers; stall/flush gating is applied at the registers.
    always_comb begin
        state_next = state;
        first_we   = 1'b0;
        imm_we     = 1'b0;
        imm_d      = '0;
        valid_d    = 1'b0;
        has_imm_d  = out_has_imm;
        case (state)
            S_FIRST: begin
                if (in_valid) begin
                    first_we = 1'b1;
                    if (is_two_word) begin
                        state_next = S_IMM;
                    end else begin
                        imm_we    = 1'b1;
                        imm_d     = '0;
                        valid_d   = 1'b1;
                        has_imm_d = 1'b0;
                    end
                end
            end
            S_IMM: begin
                // The immediate word's flag bit is data, not a marker.
                if (in_valid) begin
                    imm_we     = 1'b1;
                    imm_d      = in_word;
                    valid_d    = 1'b1;
                    has_imm_d  = 1'b1;
                    state_next = S_FIRST;
                end
            end
            default: begin
                state_next = S_FIRST;
            end
        endcase
    end

    pipe_reg_en #(.N(WORD_W)) u_instr (
        .clk   (clk),
        .clear (reset),
        .en    (first_we & ~data_hold),
        .d     (in_word),
        .q     (out_instr)
    );

    pipe_reg_en #(.N(PC_W)) u_pc (
        .clk   (clk),
        .clear (reset),
        .en    (first_we & ~data_hold),
        .d     (in_pc),
        .q     (out_pc)
    );

    pipe_reg_en #(.N(WORD_W)) u_imm (
        .clk   (clk),
        .clear (reset),
        .en    (imm_we & ~data_hold),
        .d     (imm_d),
        .q     (out_imm)
    );

    // Flush only clears the flags; the data registers may keep stale values.
    pipe_reg_en #(.N(2)) u_flags (
        .clk   (clk),
        .clear (reset | flush),
        .en    (~stall),
        .d     ({has_imm_d, valid_d}),
        .q     (flags_q)
    );

    assign out_has_imm = flags_q[1];
    assign out_valid   = flags_q[0];

endmodule
